// File: rtl/amm_mem_responder_pkg.sv
// Shared types and default widths for the Avalon-MM memory responder.
package rtl_settings_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR_BURST,
      ST_RD_WAIT,
      ST_RD_BURST
   } mem_resp_state_t;

   localparam int AMM_DATA_W  = 64;
   localparam int AMM_ADDR_W  = 10;
   localparam int AMM_BURST_W = 4;
   localparam int DATA_B_W    = AMM_DATA_W / 8;

endpackage

// File: rtl/amm_mem_responder_mem_array.sv
// Single-port RAM with byte write enables and a one-cycle registered read port.
module amm_mem_array #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [DATA_W/8-1:0]   be_i,
   output logic [DATA_W-1:0]     rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Contents are never reset; only the output register is, so the read port powers up as zero.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
      if (!rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/amm_mem_responder.sv
// Burst-capable Avalon-MM slave memory with programmable stalls and read-data bit corruption.
module amm_mem_responder
   import rtl_settings_pkg::*;
#(
   parameter int DATA_W       = AMM_DATA_W,
   parameter int ADDR_W       = AMM_ADDR_W,
   parameter int BURST_W      = AMM_BURST_W,
   parameter int RD_LATENCY   = 2,
   parameter int STALL_PERIOD = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [ADDR_W-1:0]           address_i,
   input  logic                        read_i,
   input  logic                        write_i,
   input  logic [DATA_W-1:0]           writedata_i,
   input  logic [BURST_W-1:0]          burstcount_i,
   input  logic [DATA_W/8-1:0]         byteenable_i,
   output logic                        waitrequest_o,
   output logic                        readdatavalid_o,
   output logic [DATA_W-1:0]           readdata_o,
   input  logic                        err_inj_en_i,
   input  logic [ADDR_W-1:0]           err_inj_addr_i,
   input  logic [$clog2(DATA_W)-1:0]   err_inj_bit_i,
   output logic                        proto_err_o
);

   localparam int MAX_BURST = 2 ** (BURST_W - 1);
   localparam int STALL_W   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

   mem_resp_state_t     state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BURST_W-1:0]  rem_q, rem_d;
   logic [15:0]         wait_q, wait_d;
   logic [STALL_W-1:0]  stall_q, stall_d;
   logic                proto_err_q, proto_err_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   flip_q, flip_d;

   logic                stall_now, accept_wr, accept_rd, burst_clamp;
   logic [BURST_W-1:0]  burst_eff;
   logic                ram_we, ram_re;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_rdata;

   always_comb begin
      burst_eff   = burstcount_i;
      burst_clamp = 1'b0;
      if (burstcount_i == '0) begin
         burst_eff = BURST_W'(1);
      end else if (int'(burstcount_i) > MAX_BURST) begin
         burst_eff   = BURST_W'(MAX_BURST);
         burst_clamp = 1'b1;
      end
   end

   assign stall_now = (STALL_PERIOD != 0) && (state_q == ST_IDLE) &&
                      (stall_q == STALL_W'(STALL_PERIOD - 1));
   assign waitrequest_o = !rst_i || (state_q == ST_RD_WAIT) || (state_q == ST_RD_BURST) || stall_now;
   // A simultaneous read and write is served as the write.
   assign accept_wr = rst_i && (state_q == ST_IDLE) && write_i && !stall_now;
   assign accept_rd = rst_i && (state_q == ST_IDLE) && read_i && !write_i && !stall_now;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      wait_d      = wait_q;
      stall_d     = stall_q;
      proto_err_d = proto_err_q;
      valid_d     = 1'b0;
      flip_d      = flip_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      ram_addr    = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (STALL_PERIOD != 0) begin
               stall_d = stall_now ? '0 : stall_q + STALL_W'(1);
            end
            if (accept_wr) begin
               ram_we   = 1'b1;
               ram_addr = address_i;
               addr_d   = address_i + ADDR_W'(1);
               rem_d    = burst_eff - BURST_W'(1);
               if (burst_eff != BURST_W'(1)) begin
                  state_d = ST_WR_BURST;
               end
               if (read_i || burst_clamp) begin
                  proto_err_d = 1'b1;
               end
            end else if (accept_rd) begin
               addr_d  = address_i;
               rem_d   = burst_eff;
               wait_d  = 16'(RD_LATENCY - 2);
               state_d = (RD_LATENCY > 1) ? ST_RD_WAIT : ST_RD_BURST;
               if (burst_clamp) begin
                  proto_err_d = 1'b1;
               end
            end
         end
         ST_WR_BURST: begin
            if (read_i) begin
               proto_err_d = 1'b1;
            end
            if (write_i) begin
               ram_we = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - BURST_W'(1);
               if (rem_q == BURST_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RD_WAIT: begin
            if (wait_q == '0) begin
               state_d = ST_RD_BURST;
            end else begin
               wait_d = wait_q - 16'(1);
            end
         end
         ST_RD_BURST: begin
            // One RAM read per beat; the extra cycle with rem_q==0 lets the last beat leave before IDLE.
            if (rem_q != '0) begin
               ram_re  = 1'b1;
               valid_d = 1'b1;
               addr_d  = addr_q + ADDR_W'(1);
               rem_d   = rem_q - BURST_W'(1);
               flip_d  = (err_inj_en_i && (addr_q == err_inj_addr_i)) ?
                         (DATA_W'(1) << err_inj_bit_i) : '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         wait_q      <= '0;
         stall_q     <= '0;
         proto_err_q <= 1'b0;
         valid_q     <= 1'b0;
         flip_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         wait_q      <= wait_d;
         stall_q     <= stall_d;
         proto_err_q <= proto_err_d;
         valid_q     <= valid_d;
         flip_q      <= flip_d;
      end
   end

   amm_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (writedata_i),
      .be_i    (byteenable_i),
      .rdata_o (ram_rdata)
   );

   // Both operands are registers that only change on a read beat, so the data holds between beats.
   assign readdata_o      = ram_rdata ^ flip_q;
   assign readdatavalid_o = valid_q;
   assign proto_err_o     = proto_err_q;

endmodule

// File: doc/amm_mem_responder.md
Name: amm_mem_responder

Overview:
- Burst-capable Avalon-MM slave memory: the responder end of the memory-side interface that the checker drives as initiator.
- Services single and burst writes with per-byte enables, and single and burst reads with a fixed read latency.
- Injects programmable waitrequest stalls and single-bit read-data corruption, so the checker's compare, error-capture and measure paths can be exercised in simulation or on a scratch FPGA RAM.

Parameters:
- DATA_W, 64, data bus width in bits; must be a multiple of 8.
- ADDR_W, 10, word address width; memory depth is 2**ADDR_W words.
- BURST_W, 4, burstcount width; maximum legal burst is 2**(BURST_W-1) beats.
- RD_LATENCY, 2, cycles from read acceptance to the first readdatavalid; must be >= 1.
- STALL_PERIOD, 0, when nonzero, waitrequest_o is forced high one IDLE cycle in every STALL_PERIOD cycles; 0 disables stalls.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-low reset.
- address_i  in  ADDR_W  word address.
- read_i  in  1  read request.
- write_i  in  1  write request / write beat.
- writedata_i  in  DATA_W  write data.
- burstcount_i  in  BURST_W  beats in burst; sampled on the first beat only.
- byteenable_i  in  DATA_W/8  per-byte write enables.
- waitrequest_o  out  1  slave stall.
- readdatavalid_o  out  1  read beat valid.
- readdata_o  out  DATA_W  read data.
- err_inj_en_i  in  1  enable read-data corruption.
- err_inj_addr_i  in  ADDR_W  word address to corrupt.
- err_inj_bit_i  in  $clog2(DATA_W)  bit index inverted on the corrupted beat.
- proto_err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_i low at a clock edge):
  - Output values: waitrequest_o=1, readdatavalid_o=0, readdata_o=0, proto_err_o=0.
  - FSM goes to IDLE; the stall counter clears.
  - Memory contents are NOT reset.
  - Reset mid-burst abandons the burst; no further beats are emitted.
- FSM states: IDLE, WR_BURST, RD_WAIT, RD_BURST.
- Acceptance: a command is accepted only in IDLE, on a cycle where the request is high and waitrequest_o=0.
- IDLE waitrequest: waitrequest_o=0, except on stall cycles.
- Stall cycles: with STALL_PERIOD=N>0, a free-running counter modulo N asserts waitrequest_o on count==N-1. The counter runs only in IDLE.
- Burstcount handling: burstcount_i==0 is treated as 1. Values above 2**(BURST_W-1) are clamped to that maximum and set proto_err_o.
- Write, first beat:
  - Accepted in IDLE: store writedata under byteenable at address_i.
  - Latch base address and remaining count = burst-1.
  - Go to WR_BURST if remaining>0, otherwise stay in IDLE.
- WR_BURST:
  - waitrequest_o=0.
  - Each cycle with write_i=1 stores one beat at base+k and decrements remaining; write_i=0 is a bubble and nothing is stored.
  - Return to IDLE after the last beat.
  - read_i=1 here sets proto_err_o and is otherwise ignored.
- Read acceptance:
  - Accepted in IDLE: latch address and count, go to RD_WAIT.
  - waitrequest_o=1 for the whole RD_WAIT and RD_BURST duration; one outstanding read only.
- RD_WAIT: lasts RD_LATENCY-1 cycles, then go to RD_BURST.
- RD_BURST:
  - readdatavalid_o=1 on consecutive cycles, one beat per address base, base+1, ...
  - First beat appears RD_LATENCY cycles after the acceptance edge.
  - Return to IDLE the cycle after the last beat.
  - readdata_o holds its last value while readdatavalid_o=0.
- Address arithmetic: modulo 2**ADDR_W; bursts wrap from the top word to 0.
- byteenable_i on reads is ignored.
- Error injection: if err_inj_en_i=1 and the beat address == err_inj_addr_i, readdata_o bit err_inj_bit_i is inverted on that beat only. Memory contents are unaffected.
- read_i and write_i both high in IDLE: the write is served, proto_err_o is set.
- proto_err_o clears only on reset.
- Read-after-write to the same address returns the new data; a write completes before any later read is accepted.

Decomposition:
- Shared package (rtl_settings_pkg):
  - mem_resp_state_t enum for the four FSM states.
  - Default width constants reused by the top level (AMM_DATA_W, AMM_ADDR_W, AMM_BURST_W, DATA_B_W).
- One natural sub-module, amm_mem_array:
  - Single-port RAM with byte-write enables and registered read, 1 cycle.
  - The FSM absorbs the remaining RD_LATENCY-1 cycles.
  - Isolates vendor RAM inference from the control logic.

Test Plan:
- Single write then read, no stalls: write addr 0x010, data 0x1122334455667788, be=0xFF; read addr 0x010, burst 1 -> readdatavalid_o high exactly 2 cycles after read acceptance with 0x1122334455667788; proto_err_o=0.
- Partial write: write addr 0x020 data all-ones, then write data 0, be=0x0F; read 0x020 -> 0xFFFFFFFF00000000.
- 4-beat write burst at 0x3FE carrying 0xA0, 0xA1, 0xA2, 0xA3, with one write_i bubble mid-burst -> 4-beat read at 0x3FE returns A0, A1, A2, A3 with wrap (0x3FE, 0x3FF, 0x000, 0x001); readdatavalid_o contiguous for 4 cycles.
- STALL_PERIOD=3: continuous single-beat write requests -> waitrequest_o high every 3rd IDLE cycle; no write is lost (8 writes, 8 readback matches).
- Error injection at addr 0x005, bit 7, 2-beat read from 0x004 -> beat 0 clean, beat 1 has bit 7 inverted; a re-read with err_inj_en_i=0 returns the original data.
- Read and write asserted together in IDLE -> write stored, no read beats, proto_err_o=1. Then rst_i low for 1 cycle during an 8-beat read burst -> readdatavalid_o=0 the next cycle, proto_err_o=0, waitrequest_o=1 during reset.
